// File: rtl/var_delay_line_if.sv
// ---------------------------------------------------------------------------
// var_delay_line_if
// Bundles the sample stream, the tap-length handshake and the outputs of
// var_delay_line into one interface.
//
// Signals
//   i         sample input (width bits)
//   en        shift enable; one sample enters per cycle while en=1
//   len_req   length-update request
//   len_val   requested tap length (32 bits, clamped by the DUT to 1..depth)
//   len_ack   one-cycle acceptance pulse from the DUT
//   q         chain output at the current tap
//   q_valid   q holds a genuine sample, not reset/flush fill
//   state_dbg fill-state FSM (0 = EMPTY, 1 = FILL, 2 = FULL)
//
// Handshake: the requester raises len_req with len_val stable and holds both
// until it sees len_ack=1. An edge with len_req=1 and len_ack=0 is the
// transfer. len_ack is high for exactly one cycle. A request still high
// during that ack cycle is not taken again at the next edge; it is accepted
// one edge later.
//
// Modports
//   master : the driver of the stream / requests (testbench or upstream)
//   slave  : var_delay_line itself
// ---------------------------------------------------------------------------
interface var_delay_line_if #(
  parameter int width = 1
);
  logic [width-1:0] i;
  logic             en;
  logic             len_req;
  logic [31:0]      len_val;
  logic             len_ack;
  logic [width-1:0] q;
  logic             q_valid;
  logic [1:0]       state_dbg;

  modport master (
    output i, en, len_req, len_val,
    input  len_ack, q, q_valid, state_dbg
  );

  modport slave (
    input  i, en, len_req, len_val,
    output len_ack, q, q_valid, state_dbg
  );
endinterface

// File: rtl/var_delay_line.sv
// ---------------------------------------------------------------------------
// var_delay_line
// Variable-length delay line feeding the tapped shift-register stage.
// Samples shift through a depth-stage register chain while en=1; q shows the
// stage selected by the current tap length len_cur (tap 1 = newest sample).
// The tap length is updated through a req/ack handshake. q_valid says that at
// least len_cur samples have entered since reset (or flush).
//
// Parameters
//   width  data bits per stage
//   depth  chain length; legal tap range 1..depth
//
// Ports
//   clk    clock, rising edge
//   r      asynchronous active-high reset
//   flush  (only with VAR_DELAY_FLUSH_EN) synchronous fill-count clear;
//          chain data is left alone and still shifts if en=1
//   bus    var_delay_line_if.slave: i, en, len_req, len_val, len_ack, q,
//          q_valid, state_dbg
//
// Configuration macro: VAR_DELAY_FLUSH_EN adds the flush port. Without it
// the fill counter is cleared only by r.
// ---------------------------------------------------------------------------
module var_delay_line #(
  parameter int width = 1,
  parameter int depth = 130
) (
  input  logic clk,
  input  logic r,
`ifdef VAR_DELAY_FLUSH_EN
  input  logic flush,
`endif
  var_delay_line_if.slave bus
);

  // Counter / tap width must hold the value depth itself.
  localparam int CW = $clog2(depth + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(depth);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_FILL  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  logic [width-1:0] stage_q [depth];
  logic [width-1:0] stage_d [depth];
  logic [CW-1:0]    fill_q, fill_d;
  logic [CW-1:0]    len_cur_q, len_cur_d;
  logic             len_ack_q, len_ack_d;
  state_t           state_q, state_d;

  logic             flush_w;
  logic             accept;
  logic [CW-1:0]    len_clamped;

`ifdef VAR_DELAY_FLUSH_EN
  assign flush_w = flush;
`else
  assign flush_w = 1'b0;
`endif

  // -------------------------------------------------------------------------
  // Register chain: stage 0 takes the input, every other stage takes its
  // neighbour. The length handshake never touches the chain.
  // -------------------------------------------------------------------------
  always_comb begin
    for (int k = 0; k < depth; k++) begin
      stage_d[k] = stage_q[k];
    end
    if (bus.en) begin
      stage_d[0] = bus.i;
      for (int k = 1; k < depth; k++) begin
        stage_d[k] = stage_q[k-1];
      end
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      for (int k = 0; k < depth; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < depth; k++) begin
        stage_q[k] <= stage_d[k];
      end
    end
  end

  // -------------------------------------------------------------------------
  // Length handshake. A request is taken only while no ack is showing, so an
  // ack can never be followed directly by another ack.
  // -------------------------------------------------------------------------
  always_comb begin
    if (bus.len_val == 32'd0) begin
      len_clamped = ONE_C;
    end else if (bus.len_val > 32'(depth)) begin
      len_clamped = DEPTH_C;
    end else begin
      len_clamped = bus.len_val[CW-1:0];
    end
  end

  always_comb begin
    accept    = bus.len_req && !len_ack_q;
    len_ack_d = accept;
    len_cur_d = accept ? len_clamped : len_cur_q;
  end

  // -------------------------------------------------------------------------
  // Fill counter. Saturation is taken from the FSM: once FULL, further
  // samples no longer count. Flush wins over en for the counter only.
  // -------------------------------------------------------------------------
  always_comb begin
    fill_d = fill_q;
    if (flush_w) begin
      fill_d = '0;
    end else if (bus.en && (state_q != S_FULL)) begin
      fill_d = fill_q + ONE_C;
    end
  end

  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      fill_q    <= '0;
      len_cur_q <= DEPTH_C;
      len_ack_q <= 1'b0;
    end else begin
      fill_q    <= fill_d;
      len_cur_q <= len_cur_d;
      len_ack_q <= len_ack_d;
    end
  end

  // -------------------------------------------------------------------------
  // Fill-state FSM: state register / next-state / outputs.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge r) begin
    if (r) begin
      state_q <= S_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: begin
        // A one-stage chain is full after its first sample.
        if (!flush_w && bus.en) begin
          state_d = (DEPTH_C == ONE_C) ? S_FULL : S_FILL;
        end
      end
      S_FILL: begin
        if (flush_w) begin
          state_d = S_EMPTY;
        end else if (bus.en && (fill_q == DEPTH_C - ONE_C)) begin
          state_d = S_FULL;
        end
      end
      S_FULL: begin
        if (flush_w) begin
          state_d = S_EMPTY;
        end
      end
      default: state_d = S_EMPTY;
    endcase
  end

  // Outputs come straight from registered values, so reset clears them
  // without waiting for a clock edge.
  always_comb begin
    bus.q         = stage_q[len_cur_q - ONE_C];
    bus.q_valid   = (fill_q >= len_cur_q);
    bus.len_ack   = len_ack_q;
    bus.state_dbg = state_q;
  end

endmodule

// File: tb/tb_var_delay_line.sv
// ---------------------------------------------------------------------------
// tb_var_delay_line
// Directed scenarios followed by randomized traffic, checked every cycle
// against a queue-based reference model of the delay line.
// ---------------------------------------------------------------------------
module tb_var_delay_line;
  localparam int W = 8;
  localparam int D = 130;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic r;
  always #5 clk = ~clk;

  var_delay_line_if #(.width(W)) bus ();

`ifdef VAR_DELAY_FLUSH_EN
  logic flush;
`endif

  var_delay_line #(.width(W), .depth(D)) dut (
    .clk   (clk),
    .r     (r),
`ifdef VAR_DELAY_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  // ---------------- reference model / scoreboard ----------------
  // exp_q[k] is the sample k+1 positions back (index 0 = newest).
  logic [W-1:0] exp_q [$];
  int   m_fill;
  int   m_len;
  logic m_ack;
  int   n_checks;
  int   n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_len(input logic [31:0] v);
    if (v == 32'd0) return 1;
    if (v > 32'(D)) return D;
    return int'(v);
  endfunction

  task automatic model_reset();
    exp_q.delete();
    for (int k = 0; k < D; k++) exp_q.push_back('0);
    m_fill = 0;
    m_len  = D;
    m_ack  = 1'b0;
  endtask

  task automatic check_all(input string tag);
    int exp_state;
    exp_state = (m_fill == 0) ? 0 : ((m_fill == D) ? 2 : 1);
    check({tag, "_q"},       32'(bus.q),         32'(exp_q[m_len-1]));
    check({tag, "_q_valid"}, 32'(bus.q_valid),   32'(m_fill >= m_len));
    check({tag, "_len_ack"}, 32'(bus.len_ack),   32'(m_ack));
    check({tag, "_state"},   32'(bus.state_dbg), 32'(exp_state));
  endtask

  // ---------------- driver ----------------
  // Drive one cycle of inputs, advance the model at the edge, check #1 later.
  task automatic step(input logic en, input logic [W-1:0] din, input logic req,
                      input logic [31:0] val, input string tag);
    logic acc;
    bus.en      = en;
    bus.i       = din;
    bus.len_req = req;
    bus.len_val = val;
    @(posedge clk);
    acc = req && !m_ack;
    if (en) begin
      exp_q.push_front(din);
      void'(exp_q.pop_back());
    end
`ifdef VAR_DELAY_FLUSH_EN
    if (flush) m_fill = 0;
    else
`endif
    if (en && m_fill < D) m_fill++;
    if (acc) m_len = clamp_len(val);
    m_ack = acc;
    #1;
    check_all(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic        req_hold;
    logic [31:0] req_val;
    n_checks = 0;
    n_errors = 0;
    r = 1'b1;
    bus.en = 1'b0;
    bus.i = '0;
    bus.len_req = 1'b0;
    bus.len_val = '0;
`ifdef VAR_DELAY_FLUSH_EN
    flush = 1'b0;
`endif
    model_reset();
    #1;
    check_all("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    r = 1'b0;

    // tap length 5, counting samples
    step(1'b0, '0, 1'b1, 32'd5, "len5_req");
    check("len5_ack", 32'(bus.len_ack), 32'd1);
    step(1'b0, '0, 1'b0, 32'd0, "len5_idle");
    for (int k = 1; k <= 12; k++) begin
      step(1'b1, W'(k), 1'b0, 32'd0, "len5_run");
      if (k == 4) check("len5_not_yet_valid", 32'(bus.q_valid), 32'd0);
      if (k == 5) begin
        check("len5_valid_rise", 32'(bus.q_valid), 32'd1);
        check("len5_first_q", 32'(bus.q), 32'd1);
      end
      if (k == 12) check("len5_lag", 32'(bus.q), 32'd8);
    end

    // clamping: 0 -> 1, 200 -> depth
    step(1'b0, '0, 1'b1, 32'd0, "clamp0_req");
    step(1'b0, '0, 1'b0, 32'd0, "clamp0_idle");
    check("clamp0_q_newest", 32'(bus.q), 32'd12);
    step(1'b0, '0, 1'b1, 32'd200, "clamp200_req");
    step(1'b0, '0, 1'b0, 32'd0, "clamp200_idle");
    check("clamp200_invalid", 32'(bus.q_valid), 32'd0);

    // request held three cycles: ack 1,0,1
    step(1'b0, '0, 1'b1, 32'd7, "hold_a");
    check("hold_ack1", 32'(bus.len_ack), 32'd1);
    step(1'b0, '0, 1'b1, 32'd7, "hold_b");
    check("hold_ack0", 32'(bus.len_ack), 32'd0);
    step(1'b0, '0, 1'b1, 32'd7, "hold_c");
    check("hold_ack2", 32'(bus.len_ack), 32'd1);
    step(1'b0, '0, 1'b0, 32'd0, "hold_idle");

    // en low for 10 cycles in FILL, then resume
    for (int k = 0; k < 10; k++) step(1'b0, W'($urandom), 1'b0, 32'd0, "stall");
    check("stall_q_kept", 32'(bus.q), 32'd6);
    step(1'b1, 8'hA5, 1'b0, 32'd0, "resume");

    // fill completely, then reset asynchronously mid-cycle with ack showing
    for (int k = 0; k < D; k++) step(1'b1, W'($urandom), 1'b0, 32'd0, "fill_full");
    step(1'b0, '0, 1'b1, 32'd9, "pre_reset_req");
    #2 r = 1'b1;
    #1;
    check("async_rst_q", 32'(bus.q), 32'd0);
    check("async_rst_q_valid", 32'(bus.q_valid), 32'd0);
    check("async_rst_len_ack", 32'(bus.len_ack), 32'd0);
    check("async_rst_state", 32'(bus.state_dbg), 32'd0);
    model_reset();
    @(negedge clk);
    r = 1'b0;
    step(1'b0, '0, 1'b1, 32'd9, "resample_req");
    check("resample_ack", 32'(bus.len_ack), 32'd1);
    step(1'b0, '0, 1'b0, 32'd0, "resample_idle");

`ifdef VAR_DELAY_FLUSH_EN
    // flush in FULL with tap length 4
    step(1'b0, '0, 1'b1, 32'd4, "flush_len");
    step(1'b0, '0, 1'b0, 32'd0, "flush_len_idle");
    for (int k = 0; k < D; k++) step(1'b1, W'($urandom), 1'b0, 32'd0, "flush_fill");
    flush = 1'b1;
    step(1'b0, '0, 1'b0, 32'd0, "flush_pulse");
    flush = 1'b0;
    check("flush_invalid", 32'(bus.q_valid), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      step(1'b1, W'($urandom), 1'b0, 32'd0, "flush_refill");
      if (k == 3) check("flush_refill3", 32'(bus.q_valid), 32'd0);
      if (k == 4) check("flush_refill4", 32'(bus.q_valid), 32'd1);
    end
`endif

    // randomized traffic; requests follow the hold-until-ack protocol
    req_hold = 1'b0;
    req_val  = '0;
    for (int n = 0; n < 3000; n++) begin
      if (!req_hold && $urandom_range(0, 7) == 0) begin
        req_hold = 1'b1;
        case ($urandom_range(0, 3))
          0:       req_val = 32'd0;
          1:       req_val = 32'($urandom_range(1, D));
          2:       req_val = 32'($urandom_range(D + 1, 1000));
          default: req_val = 32'($urandom_range(1, 8));
        endcase
      end
`ifdef VAR_DELAY_FLUSH_EN
      flush = ($urandom_range(0, 63) == 0);
`endif
      step($urandom_range(0, 3) != 0, W'($urandom), req_hold, req_val, "rand");
      if (bus.len_ack) req_hold = 1'b0;
    end
`ifdef VAR_DELAY_FLUSH_EN
    flush = 1'b0;
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
